pulse_stretch: RTL and testbench
================================

// Module: pulse_stretch
// PURPOSE
//   Converts single-cycle trigger pulses into level pulses of fixed width.
//   Each pulse is followed by a minimum low gap. Triggers that arrive while a pulse is in progress are queued.
//   This is the inverse of a level-to-pulse edge detector. It drives LEDs and buzzers, and downstream
//   level-sensitive logic, from one-cycle event strobes.
// PARAMETERS
//   HIGH_CYCLES  4  cycles level_out stays high per pulse (>=1)
//   GAP_CYCLES   2  minimum low cycles after each pulse (>=0)
//   MAX_PEND     3  max queued triggers (>=1)
//   CNT_W        8  width of internal cycle counter; must hold max(HIGH_CYCLES,GAP_CYCLES)-1
//   PEND_W       2  width of pending; must hold MAX_PEND
// PORTS
//   clock      in   1       system clock, rising edge
//   reset      in   1       asynchronous, active-high reset
//   trigger    in   1       one-cycle request strobe, synchronous to clock
//   clear      in   1       synchronous flush: drops queue, clears overflow, aborts pulse
//   level_out  out  1       stretched pulse, registered (Moore, high iff state==HIGH)
//   busy       out  1       high when state != IDLE
//   pending    out  PEND_W  number of queued, not-yet-started triggers
//   overflow   out  1       sticky: a trigger was dropped because the queue was full
// BEHAVIOUR
//   - Reset (async): state=IDLE, counter=0, level_out=0, busy=0, pending=0, overflow=0.
//   - FSM states IDLE, HIGH, GAP. All outputs come directly from registers.
//   - IDLE: on trigger, go to HIGH and load counter=HIGH_CYCLES-1.
//     Latency: trigger sampled at edge n gives level_out high for cycles n+1..n+HIGH_CYCLES.
//   - HIGH: decrement counter each cycle. At counter==0:
//     - if GAP_CYCLES>0, go to GAP and load GAP_CYCLES-1;
//     - else apply the start-next rule below.
//   - GAP: decrement counter. At counter==0, apply the start-next rule.
//   - Start-next rule:
//     - trigger this cycle: go to HIGH, pending unchanged (the new trigger is consumed directly);
//     - else if pending>0: go to HIGH, pending-1;
//     - else go to IDLE.
//     A new pulse starts with no intervening IDLE cycle.
//   - Trigger in HIGH/GAP when not consumed by the start-next rule: pending+1.
//     If pending==MAX_PEND, the trigger is dropped and overflow is set.
//     overflow stays set until reset or clear.
//   - Simultaneous queued-start and new trigger: net pending change is 0; never over/underflows.
//   - clear: at the next edge force IDLE, level_out=0, pending=0, overflow=0, counter=0.
//     clear has priority over trigger in the same cycle; that trigger is discarded.
//   - Reset mid-pulse: outputs drop immediately. No pulse resumes after release.
//   - Counter arithmetic is unsigned. Loads truncate to CNT_W; a parameter check
//     (initial/$error) rejects HIGH_CYCLES-1 or GAP_CYCLES-1 that do not fit.
// CONFIGURATION
//   PULSE_STRETCH_RETRIG_EN
//   - Defined: a trigger in HIGH reloads counter=HIGH_CYCLES-1, extending the current pulse.
//     It is not queued and does not affect pending or overflow. Triggers in GAP are queued as normal.
//   - Undefined: a trigger in HIGH is queued exactly like a trigger in GAP.
// TESTING (HIGH_CYCLES=4, GAP_CYCLES=2, MAX_PEND=3 unless noted)
//   1 Single trigger at cycle 5 -> level_out=1 in cycles 6-9, 0 in cycles 10-11; busy=0 from cycle 12.
//   2 Three triggers during first pulse -> pending=3; four pulses 4-high/2-low back-to-back;
//     pending steps 3,2,1,0 at each new HIGH.
//   3 Fourth extra trigger while pending=3 -> overflow=1 and stays 1; total pulses still 4;
//     clear -> overflow=0, pending=0.
//   4 Trigger on last GAP cycle with pending=0 -> HIGH on next cycle, no IDLE cycle, pending stays 0.
//     Trigger plus queued start in the same cycle -> pending unchanged.
//   5 Async reset mid-HIGH -> level_out=0 and busy=0 without a clock edge; no pulse after release.
//     clear plus trigger in the same cycle -> IDLE, pending=0.
//   6 With PULSE_STRETCH_RETRIG_EN: trigger in 3rd HIGH cycle -> level_out high 7 cycles total, pending=0.
//     Without it: 4-cycle pulse, pending=1.

Source files
------------

// File: rtl/pulse_stretch.sv
// Stretches one-cycle trigger strobes into HIGH_CYCLES-wide level pulses separated by GAP_CYCLES low cycles.
// Optional macro PULSE_STRETCH_RETRIG_EN: a trigger during HIGH extends the current pulse instead of queueing.
module pulse_stretch #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_PEND    = 3,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trigger,
    input  logic              clear,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

`ifdef PULSE_STRETCH_RETRIG_EN
    localparam bit RETRIG_EN = 1'b1;
`else
    localparam bit RETRIG_EN = 1'b0;
`endif

    localparam int G_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0]  H_LOAD   = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  G_LOAD   = CNT_W'(G_LOAD_I);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

    if (HIGH_CYCLES < 1 || ((HIGH_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_high
        $error("pulse_stretch: HIGH_CYCLES-1 must be >= 0 and fit in CNT_W bits");
    end
    if (GAP_CYCLES < 0 || (G_LOAD_I >> CNT_W) != 0) begin : g_bad_gap
        $error("pulse_stretch: GAP_CYCLES-1 must fit in CNT_W bits");
    end
    if (MAX_PEND < 1 || (MAX_PEND >> PEND_W) != 0) begin : g_bad_pend
        $error("pulse_stretch: MAX_PEND must be >= 1 and fit in PEND_W bits");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             retrig_hit;
    logic             start_next;
    logic             enqueue;

    // A phase ends when its counter reaches zero; a HIGH phase with no gap hands
    // straight to the start-next decision, as does the last GAP cycle.
    always_comb begin
        retrig_hit = RETRIG_EN && (state == ST_HIGH) && trigger;
        start_next = 1'b0;
        if (cnt == '0) begin
            if (state == ST_GAP)
                start_next = 1'b1;
            else if (state == ST_HIGH && !retrig_hit && GAP_CYCLES == 0)
                start_next = 1'b1;
        end
        enqueue = trigger && (state != ST_IDLE) && !start_next && !retrig_hit;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
            pending   <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
            pending   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (start_next) begin
                if (trigger || pending != '0) begin
                    state     <= ST_HIGH;
                    cnt       <= H_LOAD;
                    level_out <= 1'b1;
                    busy      <= 1'b1;
                    if (!trigger)
                        pending <= pending - PEND_W'(1);
                end else begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    level_out <= 1'b0;
                    busy      <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (trigger) begin
                            state     <= ST_HIGH;
                            cnt       <= H_LOAD;
                            level_out <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (retrig_hit) begin
                            cnt <= H_LOAD;
                        end else if (cnt == '0) begin
                            state     <= ST_GAP;
                            cnt       <= G_LOAD;
                            level_out <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_GAP: begin
                        cnt <= cnt - CNT_W'(1);
                    end
                    default: begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        level_out <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end

            // A full queue drops the trigger and latches overflow until reset/clear.
            if (enqueue) begin
                if (pending >= PEND_MAX)
                    overflow <= 1'b1;
                else
                    pending <= pending + PEND_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch with HIGH_CYCLES=4, GAP_CYCLES=2, MAX_PEND=3.
module tb_pulse_stretch;

    logic       clock = 1'b0;
    logic       reset;
    logic       trigger;
    logic       clear;
    logic       level_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pulse_stretch #(
        .HIGH_CYCLES(4),
        .GAP_CYCLES (2),
        .MAX_PEND   (3),
        .CNT_W      (8),
        .PEND_W     (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .trigger  (trigger),
        .clear    (clear),
        .level_out(level_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int pulses;
        logic prev;

        reset   = 1'b1;
        trigger = 1'b0;
        clear   = 1'b0;
        #2;
        check("rst_level", level_out, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_overflow", overflow, 0);
        tick();
        reset = 1'b0;
        tick();

        // 1: single trigger
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_level_%0d", i), level_out, (i < 4) ? 1 : 0);
            check($sformatf("t1_busy_%0d", i), busy, (i < 6) ? 1 : 0);
            tick();
        end

        // 2: three queued triggers -> four back-to-back pulses
        trigger = 1'b1;
        tick();
        for (int k = 0; k < 27; k++) begin
            int ep;
            ep = (k <= 3) ? k : (k < 6) ? 3 : (k < 12) ? 2 : (k < 18) ? 1 : 0;
            check($sformatf("t2_level_%0d", k), level_out, (k < 24 && (k % 6) < 4) ? 1 : 0);
            check($sformatf("t2_busy_%0d", k), busy, (k < 24) ? 1 : 0);
            check($sformatf("t2_pending_%0d", k), pending, ep);
            trigger = (k + 1 <= 3);
            tick();
        end
        trigger = 1'b0;

        // 3: a fourth extra trigger overflows
        trigger = 1'b1;
        prev   = 1'b0;
        pulses = 0;
        tick();
        for (int k = 0; k < 30; k++) begin
            if (level_out && !prev) pulses++;
            prev = level_out;
            check($sformatf("t3_overflow_%0d", k), overflow, (k >= 4) ? 1 : 0);
            trigger = (k + 1 <= 4);
            tick();
        end
        trigger = 1'b0;
        check("t3_pulses", pulses, 4);
        check("t3_overflow_end", overflow, 1);
        check("t3_pending_end", pending, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t3_clr_overflow", overflow, 0);
        check("t3_clr_pending", pending, 0);
        check("t3_clr_busy", busy, 0);

        // 4: trigger on last GAP cycle restarts without IDLE
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (5) tick();
        check("t4_lastgap_level", level_out, 0);
        check("t4_lastgap_busy", busy, 1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("t4_restart_level", level_out, 1);
        check("t4_restart_busy", busy, 1);
        check("t4_restart_pending", pending, 0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("t4_queued_pending", pending, 1);
        repeat (4) tick();
        check("t4_gap2_level", level_out, 0);
        check("t4_gap2_pending", pending, 1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("t4_both_level", level_out, 1);
        check("t4_both_pending", pending, 1);
        repeat (20) tick();
        check("t4_drain_busy", busy, 0);
        check("t4_drain_pending", pending, 0);
        check("t4_drain_overflow", overflow, 0);

        // 5: async reset mid-pulse, then clear with a simultaneous trigger
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        check("t5_high_level", level_out, 1);
        reset = 1'b1;
        #1;
        check("t5_async_level", level_out, 0);
        check("t5_async_busy", busy, 0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t5_post_level_%0d", i), level_out, 0);
        end
        check("t5_post_busy", busy, 0);
        trigger = 1'b1;
        tick();
        tick();
        check("t5_pre_clr_pending", pending, 1);
        clear = 1'b1;
        tick();
        clear   = 1'b0;
        trigger = 1'b0;
        check("t5_clr_busy", busy, 0);
        check("t5_clr_level", level_out, 0);
        check("t5_clr_pending", pending, 0);
        tick();
        tick();
        check("t5_clr_stay_level", level_out, 0);
        check("t5_clr_stay_busy", busy, 0);

        // 6: trigger during the third HIGH cycle
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("t6_level_0", level_out, 1);
        tick();
        check("t6_level_1", level_out, 1);
        tick();
        check("t6_level_2", level_out, 1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
`ifdef PULSE_STRETCH_RETRIG_EN
        check("t6_pending", pending, 0);
`else
        check("t6_pending", pending, 1);
`endif
        for (int k = 3; k < 9; k++) begin
            int el;
`ifdef PULSE_STRETCH_RETRIG_EN
            el = (k <= 6) ? 1 : 0;
`else
            el = (k == 3 || k >= 6) ? 1 : 0;
`endif
            check($sformatf("t6_level_%0d", k), level_out, el);
            tick();
        end
        repeat (30) tick();
        check("t6_end_busy", busy, 0);
        check("t6_end_overflow", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
